lsu: RTL and testbench
======================

# lsu

Load/store unit for the RV32I no-trap core, in the MEM stage directly downstream of the instruction decoder. It consumes the decoder's `mem_read_i`, `mem_write_i`, `b`, `h`, `w` and `bhu` controls, carried through the pipeline, together with the EX-stage address and store data. It runs a request/grant/response handshake with data memory, generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data. While an access is outstanding it asserts `stall` to freeze the pipeline.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low. Single clock domain.
- `mem_read_i` in 1: load request, from the decoder via the pipeline.
- `mem_write_i` in 1: store request.
- `b`, `h`, `w` in 1 each: access size, one-hot.
- `bhu` in 1: zero-extend load result.
- `addr` in 32: effective byte address from the ALU.
- `wdata` in 32: store data, taken from rs2.
- `rdata` out 32: extended load result, valid in DONE.
- `stall` out 1: freeze the PC and all pipeline registers up to and including EX/MEM.
- `misalign` out 1: one-cycle pulse; the access was dropped.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: request accepted on this edge.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.

## Operation
- FSM states:
  - IDLE to REQ: `op = mem_read_i|mem_write_i`, access aligned, `mem_gnt` low.
  - IDLE or REQ to RESP: read granted.
  - IDLE or REQ to DONE: write granted.
  - RESP to DONE: `mem_rvalid` high; the extended data is registered into `rdata`.
  - DONE to IDLE: unconditional.
- `mem_req` = (IDLE & op & aligned) | REQ. `mem_we` = `mem_write_i & ~mem_read_i`.
- Read and write asserted together: treated as a read.
- `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` are decoded from the pipeline inputs. These inputs are frozen by `stall`, so the outputs are stable until the grant.
- `stall` = op & aligned & (state != DONE). In DONE, `stall` is low, so the instruction advances exactly once and is never re-issued.
- Alignment rules:
  - `h` needs `addr[0]==0`; `w` needs `addr[1:0]==0`; `b` is always aligned.
  - A misaligned op pulses `misalign` for one cycle, with no `mem_req` and no stall.
  - A misaligned load returns `rdata` = 0. The core has no trap, so the instruction simply retires.
- Byte enables:
  - `b`: `4'b0001 << addr[1:0]`.
  - `h`: `4'b0011 << addr[1:0]`.
  - `w`: `4'b1111`.
  - No size bit set: treated as `w`.
- Store data lanes:
  - `b`: `{4{wdata[7:0]}}`.
  - `h`: `{2{wdata[15:0]}}`.
  - `w`: `wdata`.
- Load extraction:
  - `s = mem_rdata >> (8*addr[1:0])`.
  - `b`: `s[7:0]`. `h`: `s[15:0]`.
  - Sign-extended unless `bhu`, in which case zero-extended.
- `mem_rvalid` arriving in IDLE, REQ or DONE is ignored.
- Reset outputs: state IDLE; `rdata`=0; `stall`=0; `misalign`=0; `mem_req`=0.
- Reset mid-access: the FSM returns to IDLE and `mem_req` is low from the next cycle. A late `mem_rvalid` is ignored.

## Timing
- Granting store: 2 cycles (issue with grant, then DONE). `stall` high for 1 cycle.
- Load with grant on issue and `rvalid` one cycle later: 3 cycles. `stall` high for 2 cycles; `rdata` valid in DONE.
- Each cycle of `mem_gnt` or `mem_rvalid` delay adds one stall cycle. There is no timeout.
- At most one outstanding access. `mem_req` is never high in RESP or DONE.
- Non-memory instructions: zero latency, and `stall` stays low.

## Structure
- `riscv_pkg`:
  - state enum `lsu_state_t` {IDLE, REQ, RESP, DONE};
  - width constant `XLEN=32`;
  - function `size_be(b,h,w,off)`.
- Sub-module `lsu_align`: purely combinational. Computes the byte enables, store replication, load extraction/extension and the misalign flag. The FSM lives in `lsu`.

## Test plan
- SW: `addr`=0x100, `wdata`=0xDEADBEEF, grant on issue → `mem_be`=1111, `mem_addr`=0x100, stall 1 cycle, DONE next.
- SB: `addr`=0x103, `wdata`=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- Byte loads at `addr`=0x202, `mem_rdata`=0x1280FF34, `rvalid` one cycle after grant:
  - LB → `rdata`=0xFFFFFF80, stall 2 cycles.
  - LBU → `rdata`=0x00000080.
- LH at `addr`=0x2, `mem_rdata`=0x8001xxxx, `mem_gnt` delayed 3 cycles → `rdata`=0xFFFF8001, stall 5 cycles, `mem_req` held constant until the grant.
- Misaligned accesses (LW at 0x101, SH at 0x3) → `misalign` pulse, no `mem_req`, no stall, LW `rdata`=0.
- Reset asserted in RESP, then `mem_rvalid` the next cycle → IDLE, `rdata`=0, `stall`=0, response ignored. A following LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RV32I load/store path.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Byte enables for an access of the given size at byte offset off; no size bit means word.
  function automatic logic [3:0] size_be(input logic b, input logic h, input logic w,
                                         input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (b)      be = 4'b0001 << off;
    else if (h) be = 4'b0011 << off;
    else if (w) be = 4'b1111;
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic            b_i,
  input  logic            h_i,
  input  logic            w_i,
  input  logic            bhu_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            aligned_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o      = size_be(b_i, h_i, w_i, off_i);
    aligned_o = 1'b1;
    wdata_o   = wdata_i;
    shifted   = mem_rdata_i >> {off_i, 3'b000};
    rdata_o   = shifted;
    // Byte takes priority over half; anything else is handled as a word.
    if (b_i) begin
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = bhu_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (h_i) begin
      aligned_o = ~off_i[0];
      wdata_o   = {2{wdata_i[15:0]}};
      rdata_o   = bhu_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end else begin
      aligned_o = (off_i == 2'b00);
    end
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: request/grant/response handshake with data memory and pipeline stall.
module lsu
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            b,
  input  logic            h,
  input  logic            w,
  input  logic            bhu,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misalign,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] load_ext;
  logic            aligned;
  logic            op;

  lsu_align u_align (
    .b_i         (b),
    .h_i         (h),
    .w_i         (w),
    .bhu_i       (bhu),
    .off_i       (addr[1:0]),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_rdata),
    .be_o        (mem_be),
    .wdata_o     (mem_wdata),
    .rdata_o     (load_ext),
    .aligned_o   (aligned)
  );

  assign op = mem_read_i | mem_write_i;

  // Control state and load result register; a read wins when both requests are set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op && aligned) begin
            if (mem_gnt) state_q <= mem_read_i ? RESP : DONE;
            else         state_q <= REQ;
          end else if (op && mem_read_i) begin
            rdata_q <= '0;
          end
        end
        REQ:  if (mem_gnt) state_q <= mem_read_i ? RESP : DONE;
        RESP: begin
          if (mem_rvalid) begin
            rdata_q <= load_ext;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs follow the frozen pipeline inputs; held low while reset is asserted.
  assign mem_req   = rst_n & (((state_q == IDLE) & op & aligned) | (state_q == REQ));
  assign stall     = rst_n & op & aligned & (state_q != DONE);
  assign misalign  = rst_n & (state_q == IDLE) & op & ~aligned;
  assign mem_we    = mem_write_i & ~mem_read_i;
  assign mem_addr  = {addr[XLEN-1:2], 2'b00};
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i, b, h, w, bhu;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misalign, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .b           (b),
    .h           (h),
    .w           (w),
    .bhu         (bhu),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .misalign    (misalign),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic rd, input logic wr, input logic sb, input logic sh,
                       input logic sw, input logic u, input logic [31:0] a, input logic [31:0] d);
    mem_read_i = rd; mem_write_i = wr; b = sb; h = sh; w = sw; bhu = u; addr = a; wdata = d;
  endtask

  initial begin
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(); cyc();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    rst_n = 1'b1;

    // SW at 0x100, granted on issue
    cyc(); setop(0, 1, 0, 0, 1, 0, 32'h100, 32'hDEADBEEF); mem_gnt = 1'b1; #1;
    chk("sw_req", 32'(mem_req), 32'h1);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_stall1", 32'(stall), 32'h1);
    cyc(); mem_gnt = 1'b0; #1;
    chk("sw_done_stall", 32'(stall), 32'h0);
    chk("sw_done_req", 32'(mem_req), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0); #1;
    chk("nop_stall", 32'(stall), 32'h0);

    // SB at 0x103
    cyc(); setop(0, 1, 1, 0, 0, 0, 32'h103, 32'h000000A5); mem_gnt = 1'b1; #1;
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_stall", 32'(stall), 32'h1);
    cyc(); mem_gnt = 1'b0; #1;
    chk("sb_done_stall", 32'(stall), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // LB at 0x202
    cyc(); setop(1, 0, 1, 0, 0, 0, 32'h202, 32'h0); mem_gnt = 1'b1; #1;
    chk("lb_req", 32'(mem_req), 32'h1);
    chk("lb_we", 32'(mem_we), 32'h0);
    chk("lb_be", 32'(mem_be), 32'h4);
    chk("lb_addr", mem_addr, 32'h200);
    chk("lb_stall1", 32'(stall), 32'h1);
    cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1280FF34; #1;
    chk("lb_stall2", 32'(stall), 32'h1);
    chk("lb_resp_req", 32'(mem_req), 32'h0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("lb_done_stall", 32'(stall), 32'h0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // LBU at 0x202
    cyc(); setop(1, 0, 1, 0, 0, 1, 32'h202, 32'h0); mem_gnt = 1'b1; #1;
    cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1280FF34; #1;
    cyc(); mem_rvalid = 1'b0; #1;
    chk("lbu_rdata", rdata, 32'h00000080);
    chk("lbu_done_stall", 32'(stall), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // LH at 0x2, grant delayed three cycles
    cyc(); setop(1, 0, 0, 1, 0, 0, 32'h2, 32'h0); #1;
    chk("lh_be", 32'(mem_be), 32'hC);
    chk("lh_req0", 32'(mem_req), 32'h1);
    chk("lh_stall0", 32'(stall), 32'h1);
    cyc(); #1;
    chk("lh_req1", 32'(mem_req), 32'h1);
    chk("lh_stall1", 32'(stall), 32'h1);
    cyc(); #1;
    chk("lh_req2", 32'(mem_req), 32'h1);
    chk("lh_stall2", 32'(stall), 32'h1);
    cyc(); mem_gnt = 1'b1; #1;
    chk("lh_req3", 32'(mem_req), 32'h1);
    chk("lh_stall3", 32'(stall), 32'h1);
    cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80011234; #1;
    chk("lh_req4", 32'(mem_req), 32'h0);
    chk("lh_stall4", 32'(stall), 32'h1);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("lh_done_stall", 32'(stall), 32'h0);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Reset while waiting in RESP, then a stray response
    cyc(); setop(1, 0, 0, 0, 1, 0, 32'h10, 32'h0); mem_gnt = 1'b1; #1;
    cyc(); mem_gnt = 1'b0; #1;
    chk("rr_resp_stall", 32'(stall), 32'h1);
    rst_n = 1'b0; setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555; #1;
    chk("rr_rdata", rdata, 32'h0);
    chk("rr_stall", 32'(stall), 32'h0);
    chk("rr_req", 32'(mem_req), 32'h0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("rr_ignored_rdata", rdata, 32'h0);
    chk("rr_ignored_stall", 32'(stall), 32'h0);

    // LW at 0x40 after the reset
    cyc(); setop(1, 0, 0, 0, 1, 0, 32'h40, 32'h0); mem_gnt = 1'b1; #1;
    chk("lw_req", 32'(mem_req), 32'h1);
    chk("lw_be", 32'(mem_be), 32'hF);
    cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("lw_stall2", 32'(stall), 32'h1);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("lw_rdata", rdata, 32'hCAFEF00D);
    chk("lw_done_stall", 32'(stall), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Misaligned LW at 0x101
    cyc(); setop(1, 0, 0, 0, 1, 0, 32'h101, 32'h0); mem_gnt = 1'b1; #1;
    chk("mlw_misalign", 32'(misalign), 32'h1);
    chk("mlw_req", 32'(mem_req), 32'h0);
    chk("mlw_stall", 32'(stall), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0); mem_gnt = 1'b0; #1;
    chk("mlw_rdata", rdata, 32'h0);
    chk("mlw_pulse_end", 32'(misalign), 32'h0);

    // Misaligned SH at 0x3
    cyc(); setop(0, 1, 0, 1, 0, 0, 32'h3, 32'h1234); #1;
    chk("msh_misalign", 32'(misalign), 32'h1);
    chk("msh_req", 32'(mem_req), 32'h0);
    chk("msh_stall", 32'(stall), 32'h0);
    cyc(); setop(0, 0, 0, 0, 0, 0, 32'h0, 32'h0); #1;
    chk("msh_pulse_end", 32'(misalign), 32'h0);
    chk("msh_idle_req", 32'(mem_req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
